// File: rtl/mem_access_unit_pkg.sv
// Shared constants, size encodings and FSM states for the MEM-stage load/store unit.
package mem_access_unit_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RMW_RD,
      ST_WRITE,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [1:0]        i_off,
   input  logic [1:0]        i_size,
   input  logic              i_signed,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_load,
   output logic [WORD_W-1:0] o_merge
);

   logic [BYTE_W-1:0]   w_byte;
   logic [2*BYTE_W-1:0] w_half;

   always_comb begin
      case (i_off)
         2'd0:    w_byte = i_word[31:24];
         2'd1:    w_byte = i_word[23:16];
         2'd2:    w_byte = i_word[15:8];
         default: w_byte = i_word[7:0];
      endcase
      // Half lanes key off addr[1] only; addr[0] is ignored here
      w_half = i_off[1] ? i_word[15:0] : i_word[31:16];

      o_load  = i_word;
      o_merge = i_wdata;
      if (i_size == SZ_BYTE) begin
         o_load  = {{24{i_signed & w_byte[7]}}, w_byte};
         o_merge = i_word;
         case (i_off)
            2'd0:    o_merge[31:24] = i_wdata[7:0];
            2'd1:    o_merge[23:16] = i_wdata[7:0];
            2'd2:    o_merge[15:8]  = i_wdata[7:0];
            default: o_merge[7:0]   = i_wdata[7:0];
         endcase
      end else if (i_size == SZ_HALF) begin
         o_load  = {{16{i_signed & w_half[15]}}, w_half};
         o_merge = i_word;
         if (i_off[1]) o_merge[15:0]  = i_wdata[15:0];
         else          o_merge[31:16] = i_wdata[15:0];
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word port to data memory, sub-word stores by read-modify-write.
// Optional MISALIGN_CHECK_EN: misaligned half/word requests complete immediately with rsp_err.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned WORD   = WORD_W,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [WORD-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD-1:0]   mem_wdata,
   input  logic [WORD-1:0]   mem_rdata
);

   state_t            r_state;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [1:0]        r_off;
   logic [WORD-1:0]   r_wdata;

   logic              r_ready;
   logic              r_rsp_valid;
   logic [WORD-1:0]   r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_mem_w;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [WORD-1:0]   r_mem_wdata;

   logic [WORD-1:0]   w_load;
   logic [WORD-1:0]   w_merge;
   logic              w_misalign;
   logic              w_sub_word;

   lane_align u_lane_align (
      .i_word   (mem_rdata),
      .i_off    (r_off),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   assign w_sub_word = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

   always_comb begin
      w_misalign = 1'b0;
`ifdef MISALIGN_CHECK_EN
      if (req_size == SZ_HALF)      w_misalign = req_addr[0];
      else if (req_size != SZ_BYTE) w_misalign = |req_addr[1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_size      <= '0;
         r_signed    <= 1'b0;
         r_off       <= '0;
         r_wdata     <= '0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_w     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_size     <= req_size;
                  r_signed   <= req_signed;
                  r_off      <= req_addr[1:0];
                  r_wdata    <= req_wdata;
                  r_ready    <= 1'b0;
                  r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                  if (w_misalign) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= ST_RESP;
                  end else if (!req_we) begin
                     r_state <= ST_LOAD;
                  end else if (w_sub_word) begin
                     r_state <= ST_RMW_RD;
                  end else begin
                     r_mem_wdata <= req_wdata;
                     r_mem_w     <= 1'b1;
                     r_state     <= ST_WRITE;
                  end
               end
            end
            ST_LOAD: begin
               r_rsp_rdata <= w_load;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RMW_RD: begin
               r_mem_wdata <= w_merge;
               r_mem_w     <= 1'b1;
               r_state     <= ST_WRITE;
            end
            ST_WRITE: begin
               r_mem_w     <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= '0;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_ready     <= 1'b1;
               r_mem_addr  <= '0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_w     = r_mem_w;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations, a monitor pops and compares.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];

   typedef struct {
      logic [31:0] d;
      logic        e;
      int unsigned c;
   } rsp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int unsigned c;
   } wr_t;

   rsp_t rq[$];
   wr_t  wq[$];

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   mem_access_unit #(.WORD(32), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_w      (mem_w),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: combinational read, word write on the clock edge
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_w) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   rsp_t er;
   wr_t  ew;
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
               er = rq.pop_front();
               chk("rsp_rdata", rsp_rdata, er.d);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, er.e});
               chk("rsp_cycle", cyc, er.c);
            end
         end
         if (mem_w) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got mem_w at cycle %0d addr %h expected none", cyc, mem_addr);
            end else begin
               ew = wq.pop_front();
               chk("mem_addr", mem_addr, ew.a);
               chk("mem_wdata", mem_wdata, ew.d);
               chk("write_cycle", cyc, ew.c);
            end
         end
      end
   end

   // Leaves req_valid high after the handshake so the next request overlaps the busy period
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int unsigned rlat, input logic wr, input logic [31:0] wdat,
                        input int unsigned wlat);
      logic hs;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(posedge clk);
         if (req_ready) hs = 1'b1;
      end
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got no req_ready expected acceptance of addr %h", a);
      end else begin
         rq.push_back('{d: exp_rd, e: exp_err, c: cyc + rlat});
         if (wr) wq.push_back('{a: a & 32'hFFFF_FFFC, d: wdat, c: cyc + wlat});
      end
      #1;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      for (int k = 0; k < 50 && (rq.size() != 0 || wq.size() != 0); k++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[8]  = 32'h8011_22F0;
      mem[12] = 32'h1122_3344;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("reset_mem_w", {31'b0, mem_w}, 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // we, size, signed, addr, wdata, exp_rdata, exp_err, rsp_lat, write, exp_wdata, write_lat
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEAD_BEEF, 1);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h0000_00F0, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0000_22F0, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'hFFFF_8011, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 32'h0000_8011, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd3, 1'b1, 32'h20, 32'h0, 32'h8011_22F0, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b1, 32'h11AB_3344, 2);
      issue(1'b1, 2'd1, 1'b0, 32'h30, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1'b1, 32'hBEEF_3344, 2);
      issue(1'b1, 2'd3, 1'b0, 32'h14, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 1'b1, 32'h0BAD_F00D, 1);
      issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1, 32'hCAFE_F00D, 1);
      issue(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_000D, 1'b0, 2, 1'b0, 32'h0, 0);
      drain();
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("rsp_rdata_held", rsp_rdata, 32'h0000_000D);

      // Reset while in RMW_RD must abandon the store
      req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h33; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("midrst_mem_w", {31'b0, mem_w}, 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      chk("midrst_mem_wdata", mem_wdata, 32'd0);
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_mem_unchanged", mem[12], 32'hBEEF_3344);
      issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hBEEF_3344, 1'b0, 2, 1'b0, 32'h0, 0);

`ifdef MISALIGN_CHECK_EN
      issue(1'b1, 2'd2, 1'b0, 32'h41, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h0, 0);
`else
      issue(1'b1, 2'd2, 1'b0, 32'h41, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1, 32'h1234_5678, 1);
      issue(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 32'hFFFF_8011, 1'b0, 2, 1'b0, 32'h0, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0, 2, 1'b0, 32'h0, 0);
`endif
      drain();
      chk("rsp_queue_empty", rq.size(), 32'd0);
      chk("wr_queue_empty", wq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
